// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a program image over 8N1 UART and writes it
// word by word into instruction memory, holding the CPU in reset meanwhile.
// Ports: clk, reset (sync, active high), rx (async serial), start (pulse);
// mem_wen/mem_addr/mem_wdata (imem write port), busy, cpu_hold, done,
// frame_err, len_err (sticky status).
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              frame_err,
  output logic              len_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} ses_state_t;

  // ---------------- receiver ----------------
  logic          rx_m, rx_s, rx_d;
  rx_state_t     rstate, rnext;
  logic [CW-1:0] rcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic          byte_valid, stop_bad;
  logic          fall, tick_half, tick_bit;

  assign fall      = rx_d & ~rx_s;
  assign tick_half = (rcnt == HALF_END);
  assign tick_bit  = (rcnt == BIT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    unique case (rstate)
      R_IDLE:  if (fall) rnext = R_START;
      R_START: if (tick_half) rnext = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (tick_bit && bit_idx == 3'd7) rnext = R_STOP;
      R_STOP:  if (tick_bit) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt       <= '0;
      bit_idx    <= '0;
      rx_sh      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_bad   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_bad   <= 1'b0;
      // counter restarts on every state change and after each data sample
      if (rstate == R_IDLE || rnext != rstate)
        rcnt <= '0;
      else if (rstate == R_DATA && tick_bit)
        rcnt <= '0;
      else
        rcnt <= rcnt + CW'(1);
      if (rstate == R_START)
        bit_idx <= '0;
      if (rstate == R_DATA && tick_bit) begin
        rx_sh   <= {rx_s, rx_sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (rstate == R_STOP && tick_bit) begin
        byte_valid <= rx_s;
        stop_bad   <= ~rx_s;
        rx_byte    <= rx_sh;
      end
    end
  end

  // ---------------- session ----------------
  ses_state_t      state, next;
  logic [1:0]      bcnt;
  logic [31:0]     len_q, len_nxt;
  logic [31:0]     word_q, word_nxt;
  logic [ADDR_W:0] wcnt;
  logic            start_acc, last_word;

  assign len_nxt   = {rx_byte, len_q[31:8]};
  assign word_nxt  = {rx_byte, word_q[31:8]};
  assign start_acc = start && (state == IDLE || state == DONE);
  assign last_word = (32'(wcnt) + 32'd1) == len_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE:
        if (start) next = LEN;
      LEN:
        if (byte_valid && bcnt == 2'd3) begin
          if (len_nxt == 32'd0)              next = DONE;
          else if (len_nxt > 32'(DEPTH))     next = IDLE;
          else                               next = DATA;
        end
      DATA:
        if (mem_wen && last_word) next = DONE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == LEN) || (state == DATA);
    cpu_hold = busy;
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt      <= '0;
      len_q     <= '0;
      word_q    <= '0;
      wcnt      <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      frame_err <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      if (start_acc) begin
        bcnt      <= '0;
        wcnt      <= '0;
        mem_addr  <= '0;
        frame_err <= 1'b0;
        len_err   <= 1'b0;
      end else begin
        if (busy && stop_bad)
          frame_err <= 1'b1;
        if (state == LEN && byte_valid) begin
          len_q <= len_nxt;
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3 && len_nxt > 32'(DEPTH))
            len_err <= 1'b1;
        end
        if (state == DATA && byte_valid) begin
          word_q <= word_nxt;
          bcnt   <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            mem_wen   <= 1'b1;
            mem_wdata <= word_nxt;
            mem_addr  <= wcnt[ADDR_W-1:0];
          end
        end
        if (mem_wen)
          wcnt <= wcnt + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

endmodule
